// File: rtl/cpu_clock_ctrl_if.sv
// ---------------------------------------------------------------------------
// cpu_clock_ctrl_if
// Run-control bundle between the board/CPU side and the cpu_clock_ctrl block.
//
// Signals:
//   mode        run mode: 00 full speed, 01 divided, 10 single-step, 11 halt
//   div_sel     divider tap index for the divided run mode
//   step_n      raw active-low step push button
//   bp_enable   breakpoint armed
//   bp_addr     breakpoint address
//   pc          current CPU program counter
//   resume      level input, rising edge leaves a breakpoint
//   cpu_enable  CPU advances on clock edges where this is 1
//   halted      no enable can be issued without user action
//   bp_hit      breakpoint currently holding the CPU
//   cycle_count saturating count of enabled cycles
//
// Modports:
//   master  board / CPU side, drives the controls and reads the status
//   slave   the run-control block itself
// ---------------------------------------------------------------------------
interface cpu_clock_ctrl_if #(
   parameter int DIV_SEL_WIDTH = 5,
   parameter int PC_WIDTH      = 16,
   parameter int CYCLE_WIDTH   = 32
);
   logic [1:0]               mode;
   logic [DIV_SEL_WIDTH-1:0] div_sel;
   logic                     step_n;
   logic                     bp_enable;
   logic [PC_WIDTH-1:0]      bp_addr;
   logic [PC_WIDTH-1:0]      pc;
   logic                     resume;
   logic                     cpu_enable;
   logic                     halted;
   logic                     bp_hit;
   logic [CYCLE_WIDTH-1:0]   cycle_count;

   modport master (
      output mode, div_sel, step_n, bp_enable, bp_addr, pc, resume,
      input  cpu_enable, halted, bp_hit, cycle_count
   );

   modport slave (
      input  mode, div_sel, step_n, bp_enable, bp_addr, pc, resume,
      output cpu_enable, halted, bp_hit, cycle_count
   );
endinterface

// File: rtl/cpu_clock_ctrl.sv
// ---------------------------------------------------------------------------
// cpu_clock_ctrl
// Run control for the ToastCPU core. Produces a single-domain clock enable
// (cpu_enable) supporting full-speed run, divided-rate run, debounced
// single-step from a push button, and a PC breakpoint with resume.
//
// Ports:
//   clock  system clock (CLOCK_50 domain), the only clock
//   reset  asynchronous active-low reset
//   ctrl   cpu_clock_ctrl_if.slave bundle (mode, div_sel, step_n, bp_enable,
//          bp_addr, pc, resume in; cpu_enable, halted, bp_hit, cycle_count out)
// ---------------------------------------------------------------------------
module cpu_clock_ctrl #(
   parameter int DIV_WIDTH       = 27,
   parameter int DIV_SEL_WIDTH   = 5,
   parameter int DEBOUNCE_CYCLES = 500000,
   parameter int PC_WIDTH        = 16,
   parameter int CYCLE_WIDTH     = 32
) (
   input logic             clock,
   input logic             reset,
   cpu_clock_ctrl_if.slave ctrl
);

   localparam int DEB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

   typedef enum logic {
      ST_RUN   = 1'b0,
      ST_BREAK = 1'b1
   } state_t;

   state_t                   state;
   logic                     run_ok;
   logic                     skip;
   logic                     bp_hit_q;
   logic [CYCLE_WIDTH-1:0]   cycle_count;

   logic [DIV_WIDTH-1:0]     divider;
   logic [DIV_WIDTH-1:0]     divider_next;
   logic [DIV_WIDTH-1:0]     tap_mask;
   logic [DIV_SEL_WIDTH-1:0] tap_sel;
   logic                     tick;
   logic                     tick_next;

   logic                     step_meta;
   logic                     step_sync;
   logic                     step_db;
   logic                     step_db_q;
   logic [DEB_W-1:0]         db_count;
   logic                     step_armed;
   logic                     step_req;

   logic                     resume_q;
   logic                     resume_rise;

   logic [PC_WIDTH-1:0]      pc_cur;
   logic [PC_WIDTH-1:0]      bp_addr_cur;
   logic                     pc_at_bp;
   logic                     bp_match;
   logic                     grant;
   logic                     cpu_enable;
   logic                     halted;

   assign pc_cur      = ctrl.pc;
   assign bp_addr_cur = ctrl.bp_addr;
   assign pc_at_bp    = (pc_cur == bp_addr_cur);

   // Tap selection clamps out-of-range selectors to the top divider bit.
   // A tick is flagged when the selected bit is about to go 0->1, using the
   // same tap for the current and next divider value, so changing div_sel
   // can drop a tick but never fabricates one.
   always_comb begin
      tap_sel = ctrl.div_sel;
      if (int'(ctrl.div_sel) >= DIV_WIDTH) begin
         tap_sel = DIV_SEL_WIDTH'(DIV_WIDTH - 1);
      end
      divider_next = divider + DIV_WIDTH'(1);
      tap_mask     = DIV_WIDTH'(1) << tap_sel;
      tick_next    = (|(divider_next & tap_mask)) & ~(|(divider & tap_mask));
   end

   // Free-running divider and the registered tick pulse.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         divider <= '0;
         tick    <= 1'b0;
      end else begin
         divider <= divider_next;
         tick    <= tick_next;
      end
   end

   // Step button: two-flop synchronizer, counter-based debounce and a
   // one-cycle request on the debounced released->pressed edge. The sync
   // flops come out of reset reading "pressed" and the request is only
   // armed once a released level has actually been seen, so a button held
   // through reset has to be let go and pressed again to step.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         step_meta  <= 1'b0;
         step_sync  <= 1'b0;
         step_db    <= 1'b1;
         step_db_q  <= 1'b1;
         db_count   <= '0;
         step_armed <= 1'b0;
         step_req   <= 1'b0;
      end else begin
         step_meta  <= ctrl.step_n;
         step_sync  <= step_meta;
         step_db_q  <= step_db;
         step_armed <= step_armed | step_sync;
         step_req   <= step_armed & step_db_q & ~step_db;
         if (step_sync != step_db) begin
            if (db_count == DEB_W'(DEBOUNCE_CYCLES - 1)) begin
               step_db  <= step_sync;
               db_count <= '0;
            end else begin
               db_count <= db_count + DEB_W'(1);
            end
         end else begin
            db_count <= '0;
         end
      end
   end

   // Resume is a level; only its rising edge matters.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         resume_q <= 1'b0;
      end else begin
         resume_q <= ctrl.resume;
      end
   end

   assign resume_rise = ctrl.resume & ~resume_q;

   // Enable decision. A breakpoint match suppresses the enable in the very
   // cycle the CPU presents bp_addr, so that instruction is not executed.
   // Inside BREAK only a step request lets one instruction through.
   always_comb begin
      bp_match = ctrl.bp_enable & pc_at_bp & ~skip;
      case (ctrl.mode)
         2'b00:   grant = 1'b1;
         2'b01:   grant = tick;
         2'b10:   grant = step_req;
         default: grant = 1'b0;
      endcase
      cpu_enable = 1'b0;
      if (state == ST_RUN) begin
         cpu_enable = run_ok & grant & ~bp_match;
      end else begin
         cpu_enable = run_ok & step_req;
      end
      halted = bp_hit_q | (ctrl.mode == 2'b11) | ((ctrl.mode == 2'b10) & ~cpu_enable) | ~run_ok;
   end

   // Run/break state machine with the skip flag and cycle counter. skip lets
   // the CPU move off bp_addr after a resume or step without retriggering;
   // it clears as soon as the pc differs from the breakpoint address.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state       <= ST_RUN;
         bp_hit_q    <= 1'b0;
         run_ok      <= 1'b0;
         skip        <= 1'b0;
         cycle_count <= '0;
      end else begin
         run_ok <= 1'b1;
         case (state)
            ST_RUN: begin
               if (bp_match) begin
                  state    <= ST_BREAK;
                  bp_hit_q <= 1'b1;
               end
            end
            ST_BREAK: begin
               if (resume_rise) begin
                  state    <= ST_RUN;
                  bp_hit_q <= 1'b0;
               end
            end
            default: begin
               state    <= ST_RUN;
               bp_hit_q <= 1'b0;
            end
         endcase
         if ((state == ST_BREAK) && (step_req || resume_rise)) begin
            skip <= 1'b1;
         end else if (!pc_at_bp) begin
            skip <= 1'b0;
         end
         if (cpu_enable && (cycle_count != '1)) begin
            cycle_count <= cycle_count + CYCLE_WIDTH'(1);
         end
      end
   end

   assign ctrl.cpu_enable  = cpu_enable;
   assign ctrl.halted      = halted;
   assign ctrl.bp_hit      = bp_hit_q;
   assign ctrl.cycle_count = cycle_count;

endmodule

// File: tb/tb_cpu_clock_ctrl.sv
// ---------------------------------------------------------------------------
// tb_cpu_clock_ctrl
// Self-checking bench for cpu_clock_ctrl: directed sequences for run, divided
// run, debounced stepping, breakpoint/resume and reset, a table of
// breakpoint vectors, and a randomized phase checked against a cycle-level
// reference model of the run-control rules.
// ---------------------------------------------------------------------------
module tb_cpu_clock_ctrl;

   localparam int DIV_WIDTH       = 8;
   localparam int DIV_SEL_WIDTH   = 5;
   localparam int DEBOUNCE_CYCLES = 4;
   localparam int PC_WIDTH        = 16;
   localparam int CYCLE_WIDTH     = 8;

   typedef struct {
      logic [1:0]  mode;
      logic [15:0] pc;
      logic        resume;
      logic        exp_en;
      logic        exp_halt;
      logic        exp_hit;
      logic [7:0]  exp_cnt;
   } bp_vec_t;

   logic    clock;
   logic    reset;
   int      tests_run;
   int      tests_failed;
   bp_vec_t bp_table [13];

   cpu_clock_ctrl_if #(
      .DIV_SEL_WIDTH(DIV_SEL_WIDTH),
      .PC_WIDTH(PC_WIDTH),
      .CYCLE_WIDTH(CYCLE_WIDTH)
   ) bus ();

   cpu_clock_ctrl #(
      .DIV_WIDTH(DIV_WIDTH),
      .DIV_SEL_WIDTH(DIV_SEL_WIDTH),
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .PC_WIDTH(PC_WIDTH),
      .CYCLE_WIDTH(CYCLE_WIDTH)
   ) dut (
      .clock(clock),
      .reset(reset),
      .ctrl(bus)
   );

   // 10 ns clock
   initial clock = 1'b0;
   always #5 clock = ~clock;

   // One comparison: counts it, and reports it when it disagrees.
   task automatic check_output(input string name, input int actual, input int expected);
      tests_run++;
      if (actual != expected) begin
         tests_failed++;
         $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
      end
   endtask

   // Inputs change just after the rising edge, outputs are sampled on the
   // falling edge.
   task automatic next_cycle;
      @(posedge clock);
      #1;
   endtask

   task automatic settle;
      @(negedge clock);
   endtask

   task automatic apply_stimulus(input bp_vec_t v);
      bus.mode   = v.mode;
      bus.pc     = v.pc;
      bus.resume = v.resume;
   endtask

   // Holds reset, checks the reset outputs, and releases it just after a
   // rising edge; the caller is then in cycle 0 after release.
   task automatic do_reset;
      reset         = 1'b0;
      bus.mode      = 2'b00;
      bus.div_sel   = '0;
      bus.step_n    = 1'b1;
      bus.bp_enable = 1'b0;
      bus.bp_addr   = 16'h0010;
      bus.pc        = 16'h0000;
      bus.resume    = 1'b0;
      repeat (2) next_cycle();
      settle();
      check_output("reset_en", int'(bus.cpu_enable), 0);
      check_output("reset_halted", int'(bus.halted), 1);
      check_output("reset_bp_hit", int'(bus.bp_hit), 0);
      check_output("reset_count", int'(bus.cycle_count), 0);
      next_cycle();
      reset = 1'b1;
   endtask

   // Samples n cycles with the current inputs and reports the enables seen.
   task automatic count_pulses(input int n, output int pulses, output int first_pos);
      pulses    = 0;
      first_pos = -1;
      for (int c = 0; c < n; c++) begin
         settle();
         if (bus.cpu_enable) begin
            if (pulses == 0) first_pos = c;
            pulses++;
         end
         next_cycle();
      end
   endtask

   function automatic int clamp_sel(input int s);
      return (s >= DIV_WIDTH) ? DIV_WIDTH - 1 : s;
   endfunction

   // Divider value in cycle k after release is k mod 2^DIV_WIDTH; a tick
   // appears in the cycle where the chosen bit has just become 1.
   function automatic bit model_tick(input int k, input int s);
      int now_v;
      int prev_v;
      if (k == 0) return 1'b0;
      now_v  = k % (1 << DIV_WIDTH);
      prev_v = (k - 1) % (1 << DIV_WIDTH);
      return (((now_v >> s) & 1) == 1) && (((prev_v >> s) & 1) == 0);
   endfunction

   initial begin
      int p;
      int f;
      int pos[$];
      int pos2[$];
      int last_rel;
      bit m_run_ok;
      bit m_brk;
      bit m_skip;
      bit m_res_q;
      int m_cnt;
      int m_k;
      int m_prev_sel;
      bit tk;
      bit match;
      bit grant;
      bit exp_en;
      bit exp_halt;
      int r;
      logic [15:0] pc_next;

      tests_run    = 0;
      tests_failed = 0;

      // pc walks onto bp_addr 0x0010, waits in BREAK, resumes, steps past
      // it and then returns to it once more.
      bp_table[0]  = '{2'b00, 16'h000C, 1'b0, 1'b0, 1'b1, 1'b0, 8'd0};
      bp_table[1]  = '{2'b00, 16'h000D, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0};
      bp_table[2]  = '{2'b00, 16'h000E, 1'b0, 1'b1, 1'b0, 1'b0, 8'd1};
      bp_table[3]  = '{2'b00, 16'h000F, 1'b0, 1'b1, 1'b0, 1'b0, 8'd2};
      bp_table[4]  = '{2'b00, 16'h0010, 1'b0, 1'b0, 1'b0, 1'b0, 8'd3};
      bp_table[5]  = '{2'b00, 16'h0010, 1'b0, 1'b0, 1'b1, 1'b1, 8'd3};
      bp_table[6]  = '{2'b00, 16'h0010, 1'b0, 1'b0, 1'b1, 1'b1, 8'd3};
      bp_table[7]  = '{2'b00, 16'h0010, 1'b1, 1'b0, 1'b1, 1'b1, 8'd3};
      bp_table[8]  = '{2'b00, 16'h0010, 1'b1, 1'b1, 1'b0, 1'b0, 8'd3};
      bp_table[9]  = '{2'b00, 16'h0011, 1'b0, 1'b1, 1'b0, 1'b0, 8'd4};
      bp_table[10] = '{2'b00, 16'h0012, 1'b0, 1'b1, 1'b0, 1'b0, 8'd5};
      bp_table[11] = '{2'b00, 16'h0010, 1'b0, 1'b0, 1'b0, 1'b0, 8'd6};
      bp_table[12] = '{2'b00, 16'h0010, 1'b0, 1'b0, 1'b1, 1'b1, 8'd6};

      // Full-speed run from reset, then counter saturation.
      do_reset();
      settle();
      check_output("first_cycle_en", int'(bus.cpu_enable), 0);
      check_output("first_cycle_halted", int'(bus.halted), 1);
      next_cycle();
      for (int i = 1; i <= 10; i++) begin
         settle();
         check_output("run_en", int'(bus.cpu_enable), 1);
         check_output("run_halted", int'(bus.halted), 0);
         next_cycle();
      end
      settle();
      check_output("count_after_11", int'(bus.cycle_count), 10);
      repeat (250) next_cycle();
      settle();
      check_output("count_saturated", int'(bus.cycle_count), 255);
      repeat (10) next_cycle();
      settle();
      check_output("count_holds", int'(bus.cycle_count), 255);
      check_output("sat_still_en", int'(bus.cpu_enable), 1);
      next_cycle();

      // Divided run: div_sel 2 then 0 without resetting the divider.
      bus.mode    = 2'b01;
      bus.div_sel = 5'd2;
      for (int c = 0; c < 64; c++) begin
         settle();
         if (bus.cpu_enable) pos.push_back(c);
         next_cycle();
      end
      check_output("div8_pulses", pos.size(), 8);
      for (int i = 1; i < pos.size(); i++) check_output("div8_gap", pos[i] - pos[i-1], 8);
      last_rel    = (pos.size() > 0) ? pos[pos.size()-1] - 64 : 0;
      bus.div_sel = 5'd0;
      for (int c = 0; c < 22; c++) begin
         settle();
         if (c >= 2 && bus.cpu_enable) pos2.push_back(c);
         next_cycle();
      end
      check_output("div2_pulses", pos2.size(), 10);
      for (int i = 1; i < pos2.size(); i++) check_output("div2_gap", pos2[i] - pos2[i-1], 2);
      if (pos2.size() > 0) check_output("div_phase_kept", (pos2[0] - last_rel) % 2, 1);

      // Single-step with a glitch, a stable press, release and re-press.
      bus.mode = 2'b10;
      for (int c = 0; c < 4; c++) begin
         settle();
         check_output("step_idle_en", int'(bus.cpu_enable), 0);
         check_output("step_idle_halted", int'(bus.halted), 1);
         next_cycle();
      end
      bus.step_n = 1'b0;
      count_pulses(2, p, f);
      bus.step_n = 1'b1;
      begin
         int p2;
         count_pulses(4, p2, f);
         check_output("glitch_pulses", p + p2, 0);
      end
      bus.step_n = 1'b0;
      count_pulses(20, p, f);
      check_output("press_pulses", p, 1);
      check_output("press_latency", f, 7);
      bus.step_n = 1'b1;
      count_pulses(12, p, f);
      check_output("release_pulses", p, 0);
      bus.step_n = 1'b0;
      count_pulses(12, p, f);
      check_output("repress_pulses", p, 1);
      check_output("repress_latency", f, 7);
      bus.step_n = 1'b1;
      count_pulses(10, p, f);

      // Breakpoint vectors from a fresh reset.
      do_reset();
      bus.bp_enable = 1'b1;
      bus.bp_addr   = 16'h0010;
      for (int i = 0; i < 13; i++) begin
         apply_stimulus(bp_table[i]);
         settle();
         check_output($sformatf("bp_en_%0d", i), int'(bus.cpu_enable), int'(bp_table[i].exp_en));
         check_output($sformatf("bp_halted_%0d", i), int'(bus.halted), int'(bp_table[i].exp_halt));
         check_output($sformatf("bp_hit_%0d", i), int'(bus.bp_hit), int'(bp_table[i].exp_hit));
         check_output($sformatf("bp_count_%0d", i), int'(bus.cycle_count), int'(bp_table[i].exp_cnt));
         next_cycle();
      end

      // Step while in BREAK: one enable, still in BREAK.
      bus.step_n = 1'b0;
      count_pulses(12, p, f);
      check_output("break_step_pulses", p, 1);
      check_output("break_step_latency", f, 7);
      bus.step_n = 1'b1;
      count_pulses(10, p, f);
      check_output("break_idle_pulses", p, 0);
      settle();
      check_output("break_after_step_hit", int'(bus.bp_hit), 1);
      next_cycle();

      // Step and resume in the same cycle: the step enable is issued, then RUN.
      bus.step_n = 1'b0;
      count_pulses(7, p, f);
      check_output("pre_step_pulses", p, 0);
      bus.resume = 1'b1;
      settle();
      check_output("step_resume_en", int'(bus.cpu_enable), 1);
      check_output("step_resume_hit", int'(bus.bp_hit), 1);
      next_cycle();
      settle();
      check_output("after_resume_hit", int'(bus.bp_hit), 0);
      check_output("after_resume_en_at_bp", int'(bus.cpu_enable), 1);
      next_cycle();
      bus.step_n = 1'b1;
      bus.resume = 1'b0;
      bus.pc     = 16'h0011;
      settle();
      check_output("moved_off_en", int'(bus.cpu_enable), 1);
      next_cycle();
      bus.pc = 16'h0010;
      settle();
      check_output("retrigger_en", int'(bus.cpu_enable), 0);
      next_cycle();
      settle();
      check_output("retrigger_hit", int'(bus.bp_hit), 1);

      // Reset while in BREAK with the button held through reset.
      bus.step_n = 1'b0;
      #2;
      reset = 1'b0;
      #1;
      check_output("midreset_hit", int'(bus.bp_hit), 0);
      check_output("midreset_en", int'(bus.cpu_enable), 0);
      check_output("midreset_halted", int'(bus.halted), 1);
      check_output("midreset_count", int'(bus.cycle_count), 0);
      bus.bp_enable = 1'b0;
      bus.mode      = 2'b10;
      repeat (3) next_cycle();
      reset = 1'b1;
      count_pulses(20, p, f);
      check_output("held_through_reset_pulses", p, 0);
      bus.step_n = 1'b1;
      count_pulses(12, p, f);
      check_output("post_reset_release_pulses", p, 0);
      bus.step_n = 1'b0;
      count_pulses(12, p, f);
      check_output("post_reset_press_pulses", p, 1);
      check_output("post_reset_press_latency", f, 7);
      bus.step_n = 1'b1;
      count_pulses(10, p, f);

      // Halt mode ignores steps and ticks.
      bus.mode    = 2'b11;
      bus.div_sel = 5'd0;
      for (int c = 0; c < 22; c++) begin
         if (c == 0) bus.step_n = 1'b0;
         if (c == 12) bus.step_n = 1'b1;
         settle();
         check_output("halt_mode_en", int'(bus.cpu_enable), 0);
         check_output("halt_mode_halted", int'(bus.halted), 1);
         next_cycle();
      end
      bus.mode = 2'b10;
      count_pulses(10, p, f);
      check_output("discarded_step_pulses", p, 0);

      // Randomized phase against the reference model (step button idle).
      do_reset();
      m_run_ok   = 1'b0;
      m_brk      = 1'b0;
      m_skip     = 1'b0;
      m_res_q    = 1'b0;
      m_cnt      = 0;
      m_k        = 0;
      m_prev_sel = 0;
      bus.bp_enable = 1'b1;
      bus.pc        = 16'h000E;
      for (int cyc = 0; cyc < 600; cyc++) begin
         if ($urandom_range(0, 15) == 0) bus.mode = 2'($urandom_range(0, 3));
         if ($urandom_range(0, 31) == 0) begin
            r = int'($urandom_range(0, 4));
            bus.div_sel = (r == 4) ? 5'd12 : 5'(r);
         end
         if ($urandom_range(0, 5) == 0) bus.resume = ~bus.resume;
         if ($urandom_range(0, 63) == 0) bus.bp_enable = ~bus.bp_enable;
         settle();
         tk    = model_tick(m_k, m_prev_sel);
         match = bus.bp_enable && (bus.pc == bus.bp_addr) && !m_skip;
         case (bus.mode)
            2'b00:   grant = 1'b1;
            2'b01:   grant = tk;
            default: grant = 1'b0;
         endcase
         exp_en   = m_brk ? 1'b0 : (!match && m_run_ok && grant);
         exp_halt = m_brk || (bus.mode == 2'b11) || ((bus.mode == 2'b10) && !exp_en) || !m_run_ok;
         check_output("rand_en", int'(bus.cpu_enable), int'(exp_en));
         check_output("rand_halted", int'(bus.halted), int'(exp_halt));
         check_output("rand_bp_hit", int'(bus.bp_hit), int'(m_brk));
         check_output("rand_count", int'(bus.cycle_count), m_cnt);
         if (m_brk) begin
            if (bus.resume && !m_res_q) begin
               m_brk  = 1'b0;
               m_skip = 1'b1;
            end else if (bus.pc != bus.bp_addr) begin
               m_skip = 1'b0;
            end
         end else begin
            if (match) m_brk = 1'b1;
            if (bus.pc != bus.bp_addr) m_skip = 1'b0;
         end
         if (exp_en && m_cnt < 255) m_cnt++;
         m_run_ok   = 1'b1;
         m_res_q    = bus.resume;
         m_prev_sel = clamp_sel(int'(bus.div_sel));
         m_k++;
         pc_next = bus.pc;
         if (bus.cpu_enable) pc_next = bus.pc + 16'd1;
         if (pc_next > 16'h0013 || $urandom_range(0, 9) == 0) pc_next = 16'($urandom_range(16'h000D, 16'h0011));
         next_cycle();
         bus.pc = pc_next;
      end

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
